// File: rtl/controlador_fechadura_if.sv
// Keypad-side bundle of the DigiLock verification controller.
// The master drives keys and programming requests; the slave reports comparison and lock status.
interface controlador_fechadura_if;
   logic       tecla_valida;
   logic [3:0] tecla;
   logic       programar;
   logic       comparacao;
   logic       comp_valido;
   logic       destrava;
   logic       erro;
   logic       bloqueado;
   logic       programando;
   logic [1:0] tentativas;

   modport master (
      output tecla_valida, tecla, programar,
      input  comparacao, comp_valido, destrava, erro, bloqueado, programando, tentativas
   );

   modport slave (
      input  tecla_valida, tecla, programar,
      output comparacao, comp_valido, destrava, erro, bloqueado, programando, tentativas
   );
endinterface

// File: rtl/controlador_fechadura.sv
// DigiLock sequencing controller: per-digit password comparison, unlock/error/lockout
// decisions and password reprogramming while the lock is open.
//
// state    | meaning
// OCIOSO   | idle, waiting for the first digit of a code
// COLETA   | collecting code digits, inactivity timer running
// VERIFICA | one cycle to judge the complete code
// ERRO     | one cycle, erro pulse
// ABERTO   | lock open for T_ABERTO cycles, programar accepted
// PROGRAMA | shifting a new password into the shadow register
// BLOQUEIO | lockout for T_BLOQUEIO cycles, keys ignored
module controlador_fechadura #(
   parameter int                        NUM_DIGITOS    = 4,
   parameter int                        MAX_TENTATIVAS = 3,
   parameter int                        T_ABERTO       = 50,
   parameter int                        T_BLOQUEIO     = 200,
   parameter int                        T_INATIVO      = 100,
   parameter logic [4*NUM_DIGITOS-1:0]  SENHA_INICIAL  = 16'h1234
) (
   input logic                      clk,
   input logic                      rst,
   controlador_fechadura_if.slave   bus
);
   localparam int SW    = 4*NUM_DIGITOS;
   localparam int T_MAX = (T_BLOQUEIO > T_ABERTO) ?
                          ((T_BLOQUEIO > T_INATIVO) ? T_BLOQUEIO : T_INATIVO) :
                          ((T_ABERTO > T_INATIVO) ? T_ABERTO : T_INATIVO);
   localparam int TW    = $clog2(T_MAX + 1);
   localparam int IW    = $clog2(NUM_DIGITOS + 1);

   localparam logic [IW-1:0] ULTIMO      = IW'(NUM_DIGITOS - 1);
   localparam logic [TW-1:0] CARGA_ABRE  = TW'(T_ABERTO);
   localparam logic [TW-1:0] CARGA_BLOQ  = TW'(T_BLOQUEIO);
   localparam logic [TW-1:0] CARGA_INAT  = TW'(T_INATIVO);
   localparam logic [1:0]    MAX_T       = 2'(MAX_TENTATIVAS);

   typedef enum logic [2:0] {
      OCIOSO, COLETA, VERIFICA, ERRO, ABERTO, PROGRAMA, BLOQUEIO
   } estado_t;

   estado_t       estado_q;
   logic [SW-1:0] senha_q, sombra_q;
   logic [IW-1:0] idx_q;
   logic [TW-1:0] timer_q;
   logic [1:0]    tent_q;
   logic          acerto_q;
   logic          comparacao_q, comp_valido_q, destrava_q, erro_q, bloqueado_q, programando_q;

   logic          aceita_d, casa_d;
   logic [1:0]    tent_d;
   logic [3:0]    digito_d;

   always_comb begin
      digito_d = senha_q[(NUM_DIGITOS - 1 - int'(idx_q))*4 +: 4];
      casa_d   = (bus.tecla == digito_d);
      aceita_d = bus.tecla_valida && (bus.tecla <= 4'd9) &&
                 (estado_q == OCIOSO || estado_q == COLETA || estado_q == PROGRAMA);
      tent_d   = (tent_q == MAX_T) ? tent_q : tent_q + 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q      <= OCIOSO;
         senha_q       <= SENHA_INICIAL;
         sombra_q      <= '0;
         idx_q         <= '0;
         timer_q       <= '0;
         tent_q        <= '0;
         acerto_q      <= 1'b1;
         comparacao_q  <= 1'b0;
         comp_valido_q <= 1'b0;
         destrava_q    <= 1'b0;
         erro_q        <= 1'b0;
         bloqueado_q   <= 1'b0;
         programando_q <= 1'b0;
      end else begin
         comp_valido_q <= 1'b0;
         erro_q        <= 1'b0;
         case (estado_q)
            OCIOSO, COLETA: begin
               // idx/acerto sit at 0/1 in OCIOSO, so both states share the digit path
               if (aceita_d) begin
                  comp_valido_q <= 1'b1;
                  comparacao_q  <= casa_d;
                  acerto_q      <= acerto_q & casa_d;
                  timer_q       <= CARGA_INAT;
                  if (idx_q == ULTIMO) begin
                     idx_q    <= '0;
                     estado_q <= VERIFICA;
                  end else begin
                     idx_q    <= idx_q + 1'b1;
                     estado_q <= COLETA;
                  end
               end else if (estado_q == COLETA) begin
                  if (timer_q <= 1) begin
                     estado_q <= OCIOSO;
                     idx_q    <= '0;
                     acerto_q <= 1'b1;
                  end else begin
                     timer_q <= timer_q - 1'b1;
                  end
               end
            end
            VERIFICA: begin
               acerto_q <= 1'b1;
               if (acerto_q) begin
                  estado_q   <= ABERTO;
                  tent_q     <= '0;
                  destrava_q <= 1'b1;
                  timer_q    <= CARGA_ABRE;
               end else begin
                  tent_q <= tent_d;
                  if (tent_d == MAX_T) begin
                     estado_q    <= BLOQUEIO;
                     bloqueado_q <= 1'b1;
                     timer_q     <= CARGA_BLOQ;
                  end else begin
                     estado_q <= ERRO;
                     erro_q   <= 1'b1;
                  end
               end
            end
            ERRO: estado_q <= OCIOSO;
            ABERTO: begin
               if (bus.programar) begin
                  estado_q      <= PROGRAMA;
                  destrava_q    <= 1'b0;
                  programando_q <= 1'b1;
                  timer_q       <= CARGA_INAT;
                  idx_q         <= '0;
               end else if (timer_q <= 1) begin
                  estado_q   <= OCIOSO;
                  destrava_q <= 1'b0;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            PROGRAMA: begin
               if (aceita_d) begin
                  sombra_q <= {sombra_q[SW-5:0], bus.tecla};
                  timer_q  <= CARGA_INAT;
                  if (idx_q == ULTIMO) begin
                     senha_q       <= {sombra_q[SW-5:0], bus.tecla};
                     estado_q      <= OCIOSO;
                     programando_q <= 1'b0;
                     idx_q         <= '0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else if (timer_q <= 1) begin
                  estado_q      <= OCIOSO;
                  programando_q <= 1'b0;
                  idx_q         <= '0;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            BLOQUEIO: begin
               if (timer_q <= 1) begin
                  estado_q    <= OCIOSO;
                  bloqueado_q <= 1'b0;
                  tent_q      <= '0;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            default: estado_q <= OCIOSO;
         endcase
      end
   end

   assign bus.comparacao  = comparacao_q;
   assign bus.comp_valido = comp_valido_q;
   assign bus.destrava    = destrava_q;
   assign bus.erro        = erro_q;
   assign bus.bloqueado   = bloqueado_q;
   assign bus.programando = programando_q;
   assign bus.tentativas  = tent_q;
endmodule

// File: tb/tb_controlador_fechadura.sv
// Bench for controlador_fechadura: directed scenarios plus random keys, every output
// compared each cycle against a code-level reference model.
module tb_controlador_fechadura;
   localparam int T_AB  = 5;
   localparam int T_BQ  = 10;
   localparam int T_IN  = 8;
   localparam int N_DIG = 4;
   localparam int MAX_T = 3;

   logic clk, rst;
   controlador_fechadura_if bus ();

   controlador_fechadura #(
      .NUM_DIGITOS(N_DIG), .MAX_TENTATIVAS(MAX_T), .T_ABERTO(T_AB),
      .T_BLOQUEIO(T_BQ), .T_INATIVO(T_IN), .SENHA_INICIAL(16'h1234)
   ) dut (.clk(clk), .rst(rst), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic confere(input string tag, input int obs, input int esp);
      total++;
      if (obs != esp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, esp, $time);
      end
   endtask

   // Reference model: the user is either idle, typing a code, being judged, seeing an
   // error, enjoying an open lock, typing a new password, or waiting out a lockout.
   localparam int M_IDLE = 0, M_TYPING = 1, M_JUDGE = 2, M_ERR = 3,
                  M_OPEN = 4, M_NEWPW = 5, M_LOCKED = 6;
   int         m_mode;
   logic [3:0] m_pw[N_DIG];
   logic [3:0] m_new[N_DIG];
   int         m_typed[$];
   int         m_quiet, m_elapsed, m_fails;
   bit         e_comp, e_cv, e_dest, e_erro, e_bloq, e_prog;

   function automatic void model_reset();
      m_mode = M_IDLE;
      m_pw[0] = 4'd1; m_pw[1] = 4'd2; m_pw[2] = 4'd3; m_pw[3] = 4'd4;
      m_typed.delete();
      m_quiet = 0; m_elapsed = 0; m_fails = 0;
      e_comp = 0; e_cv = 0; e_dest = 0; e_erro = 0; e_bloq = 0; e_prog = 0;
   endfunction

   function automatic bit code_ok();
      for (int i = 0; i < N_DIG; i++)
         if (m_typed[i] != int'(m_pw[i])) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_step(input bit v, input int k, input bit p);
      bit acc;
      acc  = v && k <= 9 && (m_mode == M_IDLE || m_mode == M_TYPING || m_mode == M_NEWPW);
      e_cv = 0;
      e_erro = 0;
      case (m_mode)
         M_IDLE, M_TYPING: begin
            if (acc) begin
               e_cv   = 1;
               e_comp = (k == int'(m_pw[m_typed.size()]));
               m_typed.push_back(k);
               m_quiet = 0;
               m_mode  = (m_typed.size() == N_DIG) ? M_JUDGE : M_TYPING;
            end else if (m_mode == M_TYPING) begin
               m_quiet++;
               if (m_quiet == T_IN) begin
                  m_mode = M_IDLE;
                  m_typed.delete();
               end
            end
         end
         M_JUDGE: begin
            if (code_ok()) begin
               m_mode = M_OPEN; m_fails = 0; e_dest = 1; m_elapsed = 0;
            end else begin
               if (m_fails < MAX_T) m_fails++;
               if (m_fails == MAX_T) begin
                  m_mode = M_LOCKED; e_bloq = 1; m_elapsed = 0;
               end else begin
                  m_mode = M_ERR; e_erro = 1;
               end
            end
            m_typed.delete();
         end
         M_ERR: m_mode = M_IDLE;
         M_OPEN: begin
            if (p) begin
               m_mode = M_NEWPW; e_dest = 0; e_prog = 1; m_quiet = 0;
               m_typed.delete();
            end else begin
               m_elapsed++;
               if (m_elapsed == T_AB) begin
                  m_mode = M_IDLE; e_dest = 0;
               end
            end
         end
         M_NEWPW: begin
            if (acc) begin
               m_new[m_typed.size()] = 4'(k);
               m_typed.push_back(k);
               m_quiet = 0;
               if (m_typed.size() == N_DIG) begin
                  m_pw = m_new;
                  m_mode = M_IDLE; e_prog = 0;
                  m_typed.delete();
               end
            end else begin
               m_quiet++;
               if (m_quiet == T_IN) begin
                  m_mode = M_IDLE; e_prog = 0;
                  m_typed.delete();
               end
            end
         end
         M_LOCKED: begin
            m_elapsed++;
            if (m_elapsed == T_BQ) begin
               m_mode = M_IDLE; e_bloq = 0; m_fails = 0;
            end
         end
         default: m_mode = M_IDLE;
      endcase
   endfunction

   task automatic confere_saidas(input string ctx);
      confere({ctx, ".comparacao"},  int'(bus.comparacao),  int'(e_comp));
      confere({ctx, ".comp_valido"}, int'(bus.comp_valido), int'(e_cv));
      confere({ctx, ".destrava"},    int'(bus.destrava),    int'(e_dest));
      confere({ctx, ".erro"},        int'(bus.erro),        int'(e_erro));
      confere({ctx, ".bloqueado"},   int'(bus.bloqueado),   int'(e_bloq));
      confere({ctx, ".programando"}, int'(bus.programando), int'(e_prog));
      confere({ctx, ".tentativas"},  int'(bus.tentativas),  m_fails);
   endtask

   // Called #1 after a rising edge; drives one cycle of inputs and checks the result.
   task automatic passo(input string ctx, input bit v, input int k, input bit p);
      bus.tecla_valida = v;
      bus.tecla        = 4'(k);
      bus.programar    = p;
      model_step(v, k, p);
      @(posedge clk);
      #1;
      confere_saidas(ctx);
      bus.tecla_valida = 1'b0;
      bus.programar    = 1'b0;
   endtask

   task automatic tecla(input string ctx, input int k);
      passo(ctx, 1'b1, k, 1'b0);
   endtask

   task automatic espera(input string ctx, input int n);
      for (int i = 0; i < n; i++) passo(ctx, 1'b0, 0, 1'b0);
   endtask

   task automatic codigo(input string ctx, input int a, input int b, input int c, input int d);
      tecla(ctx, a); tecla(ctx, b); tecla(ctx, c); tecla(ctx, d);
   endtask

   task automatic reset_meio(input string ctx);
      rst = 1'b1;
      model_reset();
      #2;
      confere_saidas({ctx, ".async"});
      @(posedge clk);
      #1;
      rst = 1'b0;
      confere_saidas({ctx, ".held"});
   endtask

   initial begin
      bus.tecla_valida = 1'b0;
      bus.tecla        = 4'd0;
      bus.programar    = 1'b0;
      rst = 1'b1;
      model_reset();
      #30;
      rst = 1'b0;
      confere_saidas("reset");
      @(posedge clk);
      #1;

      // 1: correct code opens for T_AB cycles
      codigo("t1", 1, 2, 3, 4);
      espera("t1.open", T_AB + 3);

      // 2: one wrong digit
      codigo("t2", 1, 2, 9, 4);
      espera("t2.err", 3);

      // 3: two more wrong codes reach lockout, keys ignored, then unlock
      codigo("t3a", 9, 9, 9, 9);
      espera("t3a", 2);
      codigo("t3b", 0, 0, 0, 0);
      espera("t3b", 2);
      codigo("t3.locked", 1, 2, 3, 4);
      espera("t3.locked", T_BQ);
      codigo("t3.unlock", 1, 2, 3, 4);
      espera("t3.unlock", T_AB + 2);

      // 4: reprogram to 5678
      codigo("t4", 1, 2, 3, 4);
      espera("t4", 2);
      passo("t4.prog", 1'b0, 0, 1'b1);
      codigo("t4.new", 5, 6, 7, 8);
      espera("t4", 1);
      codigo("t4.old", 1, 2, 3, 4);
      espera("t4.old", 3);
      codigo("t4.newcode", 5, 6, 7, 8);
      espera("t4.newcode", T_AB + 2);

      // 5: partial entry discarded by inactivity, then invalid key code
      tecla("t5", 1); tecla("t5", 2);
      espera("t5.idle", T_IN);
      codigo("t5.fresh", 3, 4, 1, 2);
      espera("t5", 3);
      tecla("t5.k11", 11);
      espera("t5", 2);

      // 6: reset during collection and during programming
      tecla("t6", 1); tecla("t6", 2);
      reset_meio("t6.coleta");
      codigo("t6.open", 1, 2, 3, 4);
      espera("t6", 2);
      passo("t6.prog", 1'b0, 0, 1'b1);
      tecla("t6.new", 5); tecla("t6.new", 6);
      reset_meio("t6.programa");
      codigo("t6.restored", 1, 2, 3, 4);
      espera("t6.restored", T_AB + 2);

      // random traffic, biased towards the current password
      for (int n = 0; n < 3000; n++) begin
         int r, k;
         bit v, p;
         r = int'($urandom_range(0, 199));
         if (r == 0) begin
            reset_meio("rnd.rst");
         end else begin
            v = (r < 110);
            if ($urandom_range(0, 3) == 0) k = int'($urandom_range(0, 15));
            else k = int'(m_pw[m_typed.size() % N_DIG]);
            p = ($urandom_range(0, 7) == 0);
            passo("rnd", v, k, p);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
